alu_op_sequencer: RTL
=====================

Name: alu_op_sequencer

Overview:
- Upstream issue/sequencing stage for the ALU.
- Accepts one operation at a time over a valid/ready request interface and registers the operands.
- Drives the ALU control and operand inputs, holding them stable for as long as the op needs them.
- Waits a single cycle for add/sub/shift ops; for multiply, handshakes with the multi-cycle multiplier.
- Returns the captured result and hi word over a valid/ready response interface, and flags illegal opcodes and multiply timeouts.

Parameters:
- MUL_TIMEOUT, 64: max cycles spent in MUL_WAIT before the op is aborted with an error.
- CNT_W, 7: width of the timeout counter; must satisfy 2^CNT_W > MUL_TIMEOUT.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- in_valid  input  1  request valid.
- in_ready  output  1  request ready; high only in IDLE.
- in_op  input  3  opcode: 000 add, 001 sub, 010 mul, 011 shl, 100 shr, 101-111 illegal.
- in_a  input  32  operand A.
- in_b  input  32  operand B.
- alu_ctrl  output  3  to ALU c_control.
- alu_a  output  32  to ALU srcA.
- alu_b  output  32  to ALU srcB.
- alu_result  input  32  from ALU result.
- alu_hi  input  32  from ALU hi, upper product word.
- mul_valid  input  1  multiplier done flag.
- mul_start  output  1  one-cycle pulse restarting the multiplier on held operands.
- out_valid  output  1  response valid.
- out_ready  input  1  response ready.
- out_result  output  32  captured result.
- out_hi  output  32  captured hi word; 0 for non-multiply ops.
- out_err  output  1  1 = illegal opcode or multiply timeout.

Behaviour:
- Reset: state IDLE. in_ready=1 (combinational from IDLE). alu_ctrl=0, alu_a=0, alu_b=0, mul_start=0, out_valid=0, out_result=0, out_hi=0, out_err=0, counter=0.
- States: IDLE, EXEC, MUL_START, MUL_WAIT, DONE.
- IDLE:
  - On an edge with in_valid & in_ready, latch op, a and b into alu_ctrl, alu_a and alu_b.
  - Next state: legal non-mul op -> EXEC; op 010 -> MUL_START; illegal op -> DONE with out_err=1, out_result=0, out_hi=0, and alu_* left unchanged.
- EXEC: one cycle. At the next edge, out_result<=alu_result, out_hi<=0, out_err<=0, -> DONE.
- MUL_START: mul_start=1 for exactly one cycle, counter<=0, -> MUL_WAIT. A mul_valid seen during MUL_START is stale and is ignored.
- MUL_WAIT: counter increments each cycle.
  - If mul_valid=1: out_result<=alu_result, out_hi<=alu_hi, out_err<=0, -> DONE.
  - Else if counter == MUL_TIMEOUT-1: out_result<=0, out_hi<=0, out_err<=1, -> DONE.
  - If mul_valid and timeout coincide, mul_valid wins and no error is flagged.
- DONE:
  - out_valid=1; out_result, out_hi and out_err are held stable.
  - On out_ready=1: out_valid drops at the next edge and state -> IDLE.
  - out_ready=0 holds the response indefinitely.
- alu_ctrl, alu_a and alu_b stay constant from acceptance until the next acceptance. The multiplier sees stable operands throughout.
- Latency, acceptance edge N:
  - Non-mul op: out_valid high after edge N+2.
  - Illegal op: out_valid high after edge N+1.
  - Mul op: out_valid high 1 edge after the first mul_valid seen in MUL_WAIT.
- Throughput:
  - in_ready is low from acceptance until the response is consumed and state returns to IDLE.
  - Minimum 3 cycles per non-mul op when out_ready is held high.
- Reset asserted mid-operation: immediate return to IDLE with all reset values. Any in-flight op is discarded with no response; mul_start is forced to 0.
- No combinational path from in_* to out_*. in_ready depends only on state.

Test Plan:
- Reset state: assert reset=0 mid-stream -> out_valid=0, in_ready=1, mul_start=0, all data outputs 0 while reset is low and after release.
- Add op: in_op=000, a=0x0000_0005, b=0x0000_0007, ALU model sum -> out_valid at N+2, out_result=0x0000_000C, out_hi=0, out_err=0. in_ready is low in cycles N+1 through DONE.
- Multiply with model latency 10: a=0x0001_0000, b=0x0001_0000 ->
  - single mul_start pulse;
  - response after mul_valid with out_result=0x0000_0000, out_hi=0x0000_0001, out_err=0;
  - alu_a/alu_b stable throughout.
- Multiply timeout: model never raises mul_valid -> out_valid exactly MUL_TIMEOUT+1 cycles after MUL_START with out_err=1, out_result=0. Then accept an add op to confirm recovery.
- Illegal op: in_op=110 -> out_valid at N+1, out_err=1, out_result=0. alu_ctrl is unchanged from the previous op.
- Backpressure and reset: hold out_ready=0 for 20 cycles in DONE -> outputs stable, in_ready=0. Then pulse reset low in MUL_WAIT on a later mul op -> IDLE, no response emitted.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: issue stage in front of the ALU. Takes one op at a time
// over valid/ready, holds the ALU controls/operands steady while the op runs,
// handshakes with the multi-cycle multiplier for mul, and returns the
// captured result over a valid/ready response port.
module alu_op_sequencer #(
   parameter int unsigned MUL_TIMEOUT = 64,
   parameter int unsigned CNT_W       = 7
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [2:0]  in_op,
   input  logic [31:0] in_a,
   input  logic [31:0] in_b,
   output logic [2:0]  alu_ctrl,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   input  logic [31:0] alu_result,
   input  logic [31:0] alu_hi,
   input  logic        mul_valid,
   output logic        mul_start,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_result,
   output logic [31:0] out_hi,
   output logic        out_err
);

   typedef enum logic [2:0] {
      IDLE,
      EXEC,
      MUL_START,
      MUL_WAIT,
      DONE
   } state_t;

   localparam logic [2:0]       OP_MUL        = 3'b010;
   localparam logic [2:0]       OP_LAST_LEGAL = 3'b100;
   localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(MUL_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [2:0]       r_ctrl;
   logic [31:0]      r_a;
   logic [31:0]      r_b;
   logic [31:0]      r_result;
   logic [31:0]      r_hi;
   logic             r_err;
   logic             w_accept;
   logic             w_legal;
   logic             w_is_mul;
   logic             w_timeout;

   assign w_accept  = in_valid && (r_state == IDLE);
   assign w_legal   = (in_op <= OP_LAST_LEGAL);
   assign w_is_mul  = (in_op == OP_MUL);
   assign w_timeout = (r_cnt == CNT_LAST);

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state decode
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (in_valid) begin
               if (!w_legal)     w_state_nxt = DONE;
               else if (w_is_mul) w_state_nxt = MUL_START;
               else              w_state_nxt = EXEC;
            end
         end
         EXEC:      w_state_nxt = DONE;
         MUL_START: w_state_nxt = MUL_WAIT;
         MUL_WAIT:  if (mul_valid || w_timeout) w_state_nxt = DONE;
         DONE:      if (out_ready) w_state_nxt = IDLE;
         default:   w_state_nxt = IDLE;
      endcase
   end

   // Operand capture; illegal ops leave the ALU inputs untouched
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ctrl <= '0;
         r_a    <= '0;
         r_b    <= '0;
      end else if (w_accept && w_legal) begin
         r_ctrl <= in_op;
         r_a    <= in_a;
         r_b    <= in_b;
      end
   end

   // Multiply timeout counter, cleared while the start pulse is out
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                    r_cnt <= '0;
      else if (r_state == MUL_START) r_cnt <= '0;
      else if (r_state == MUL_WAIT)  r_cnt <= r_cnt + CNT_ONE;
   end

   // Response capture; mul_valid takes priority over a same-cycle timeout
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_result <= '0;
         r_hi     <= '0;
         r_err    <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept && !w_legal) begin
                  r_result <= '0;
                  r_hi     <= '0;
                  r_err    <= 1'b1;
               end
            end
            EXEC: begin
               r_result <= alu_result;
               r_hi     <= '0;
               r_err    <= 1'b0;
            end
            MUL_WAIT: begin
               if (mul_valid) begin
                  r_result <= alu_result;
                  r_hi     <= alu_hi;
                  r_err    <= 1'b0;
               end else if (w_timeout) begin
                  r_result <= '0;
                  r_hi     <= '0;
                  r_err    <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready   = (r_state == IDLE);
   assign mul_start  = (r_state == MUL_START);
   assign out_valid  = (r_state == DONE);
   assign alu_ctrl   = r_ctrl;
   assign alu_a      = r_a;
   assign alu_b      = r_b;
   assign out_result = r_result;
   assign out_hi     = r_hi;
   assign out_err    = r_err;

endmodule
